// File: rtl/gbc_timer_array.sv
// Multi-channel memory-mapped timer block: one free-running 16-bit prescaler (DIV)
// plus NUM_CH 8-bit counters with modulo reload, rate select, one-shot mode and sticky flags.
module gbc_timer_array #(
  parameter int          NUM_CH    = 2,
  parameter logic [15:0] BASE_ADDR = 16'hFF80,
  parameter int          TAP0      = 10,
  parameter int          TAP1      = 4,
  parameter int          TAP2      = 6,
  parameter int          TAP3      = 8
) (
  input  logic              I_CLOCK,
  input  logic              I_RESET,
  input  logic [15:0]       I_ADDR,
  inout  wire  [7:0]        IO_DATA,
  input  logic              I_RE_L,
  input  logic              I_WE_L,
  output logic              O_TIMER_INTERRUPT,
  output logic [NUM_CH-1:0] O_FLAGS,
  output logic [7:0]        O_DIV_DATA
);

  localparam int SPAN = 4 + 4 * NUM_CH;

  typedef struct packed {
    logic       irq_en;
    logic       one_shot;
    logic [1:0] rate;
    logic       en;
  } ctl_t;

  logic [15:0]       prescaler;
  logic [7:0]        cnt [NUM_CH];
  logic [7:0]        mod [NUM_CH];
  ctl_t              ctl [NUM_CH];
  logic [NUM_CH-1:0] sel_q;
  logic [NUM_CH-1:0] flag;

  logic [15:0]       off;
  logic              in_blk, hit_div, hit_if, wr, rd_hit;
  logic [7:0]        wdata, rd_data;
  logic [NUM_CH-1:0] hit_cnt, hit_mod, hit_ctl, tap_sel, tick, ovf;
  logic [7:0]        reload [NUM_CH];

  assign off     = I_ADDR - BASE_ADDR;
  assign in_blk  = (I_ADDR >= BASE_ADDR) && (off < 16'(SPAN));
  assign hit_div = in_blk && (off == 16'd0);
  assign hit_if  = in_blk && (off == 16'd1);
  assign wr      = ~I_WE_L;
  assign wdata   = IO_DATA;

  // Per-channel decode, tick detection and overflow qualification.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hit_cnt = '0;
    hit_mod = '0;
    hit_ctl = '0;
    tap_sel = '0;
    tick    = '0;
    ovf     = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      reload[n]  = mod[n];
      hit_cnt[n] = in_blk && (off == 16'(4 + 4 * n));
      hit_mod[n] = in_blk && (off == 16'(5 + 4 * n));
      hit_ctl[n] = in_blk && (off == 16'(6 + 4 * n));
      case (ctl[n].rate)
        2'b00:   tap_sel[n] = prescaler[TAP0];
        2'b01:   tap_sel[n] = prescaler[TAP1];
        2'b10:   tap_sel[n] = prescaler[TAP2];
        default: tap_sel[n] = prescaler[TAP3];
      endcase
      tap_sel[n] = tap_sel[n] & ctl[n].en;
      tick[n]    = sel_q[n] & ~tap_sel[n];
      // A CPU write to CNT on the tick edge suppresses the overflow entirely.
      ovf[n]     = tick[n] && (cnt[n] == 8'hFF) && !(wr && hit_cnt[n]);
      if (wr && hit_mod[n]) reload[n] = wdata;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      prescaler <= '0;
      sel_q     <= '0;
      flag      <= '0;
      // NOTE: the per-channel arrays are a handful of flops, not RAM, so they are reset like any register.
      for (int n = 0; n < NUM_CH; n++) begin
        cnt[n] <= '0;
        mod[n] <= '0;
        ctl[n] <= '0;
      end
    end else begin
      prescaler <= (wr && hit_div) ? 16'd0 : prescaler + 16'd1;
      sel_q     <= tap_sel;
      for (int n = 0; n < NUM_CH; n++) begin
        if (wr && hit_cnt[n])
          cnt[n] <= wdata;
        else if (tick[n])
          cnt[n] <= ovf[n] ? reload[n] : cnt[n] + 8'd1;
        if (wr && hit_mod[n]) mod[n] <= wdata;
        if (wr && hit_ctl[n]) ctl[n] <= ctl_t'(wdata[4:0]);
        // Later assignment wins: a one-shot expiry beats an enable written on the same edge.
        if (ovf[n] && ctl[n].one_shot) ctl[n].en <= 1'b0;
        if (ovf[n])
          flag[n] <= 1'b1;
        else if (wr && hit_if && wdata[n])
          flag[n] <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    if (hit_div) begin
      rd_data = prescaler[15:8];
      rd_hit  = 1'b1;
    end
    if (hit_if) begin
      rd_data[NUM_CH-1:0] = flag;
      rd_hit              = 1'b1;
    end
    for (int n = 0; n < NUM_CH; n++) begin
      if (hit_cnt[n]) begin
        rd_data = cnt[n];
        rd_hit  = 1'b1;
      end
      if (hit_mod[n]) begin
        rd_data = mod[n];
        rd_hit  = 1'b1;
      end
      if (hit_ctl[n]) begin
        rd_data = {3'b000, ctl[n]};
        rd_hit  = 1'b1;
      end
    end
  end

  assign IO_DATA = (!I_RE_L && rd_hit) ? rd_data : 8'hzz;

  always_comb begin
    O_TIMER_INTERRUPT = 1'b0;
    for (int n = 0; n < NUM_CH; n++)
      O_TIMER_INTERRUPT = O_TIMER_INTERRUPT | (flag[n] & ctl[n].irq_en);
  end

  assign O_FLAGS    = flag;
  assign O_DIV_DATA = prescaler[15:8];

endmodule

// File: tb/tb_gbc_timer_array.sv
// Randomised scoreboard bench for gbc_timer_array; a behavioural model predicts every
// bus read and the debug/interrupt outputs, and a negedge monitor compares them.
module tb_gbc_timer_array;

  localparam int          NUM_CH = 2;
  localparam logic [15:0] BASE   = 16'hFF80;
  localparam int          SPAN   = 4 + 4 * NUM_CH;
  localparam logic [7:0]  PULL   = 8'hFF;   // value an undriven bus settles to

  logic              I_CLOCK = 1'b0;
  logic              I_RESET = 1'b1;
  logic [15:0]       I_ADDR  = 16'h0000;
  logic              I_RE_L  = 1'b1;
  logic              I_WE_L  = 1'b1;
  logic              O_TIMER_INTERRUPT;
  logic [NUM_CH-1:0] O_FLAGS;
  logic [7:0]        O_DIV_DATA;
  logic              tb_drive = 1'b0;
  logic [7:0]        tb_wdata = 8'h00;
  wire  [7:0]        io_data;

  assign io_data = tb_drive ? tb_wdata : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup pu (io_data[i]);
  end

  gbc_timer_array #(.NUM_CH(NUM_CH), .BASE_ADDR(BASE), .TAP0(10), .TAP1(4), .TAP2(6), .TAP3(8)) dut (
    .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_ADDR(I_ADDR), .IO_DATA(io_data),
    .I_RE_L(I_RE_L), .I_WE_L(I_WE_L), .O_TIMER_INTERRUPT(O_TIMER_INTERRUPT),
    .O_FLAGS(O_FLAGS), .O_DIV_DATA(O_DIV_DATA)
  );

  always #5 I_CLOCK = ~I_CLOCK;

  int n_checks = 0;
  int n_errors = 0;
  bit checks_on = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int         taps [4] = '{10, 4, 6, 8};
  bit [15:0]  m_pre;
  bit [7:0]   m_cnt [NUM_CH];
  bit [7:0]   m_mod [NUM_CH];
  bit         m_en [NUM_CH], m_os [NUM_CH], m_irq [NUM_CH], m_selq [NUM_CH], m_flag [NUM_CH];
  bit [1:0]   m_rate [NUM_CH];

  function automatic bit tap_val(input int c);
    return m_en[c] && (((m_pre >> taps[m_rate[c]]) & 16'd1) == 16'd1);
  endfunction

  function automatic bit tick_next(input int c);
    return m_selq[c] && !tap_val(c);
  endfunction

  // Offset of an address within the block, or -1 when outside it.
  function automatic int blk_off(input logic [15:0] a);
    if (a < BASE || int'(a - BASE) >= SPAN) return -1;
    return int'(a - BASE);
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a);
    int o, c;
    o = blk_off(a);
    if (o == 0) return m_pre[15:8];
    if (o == 1) begin
      logic [7:0] f = '0;
      for (int i = 0; i < NUM_CH; i++) f[i] = m_flag[i];
      return f;
    end
    if (o >= 4) begin
      c = (o - 4) / 4;
      case ((o - 4) % 4)
        0: return m_cnt[c];
        1: return m_mod[c];
        2: return {3'b000, m_irq[c], m_os[c], m_rate[c], m_en[c]};
        default: return PULL;
      endcase
    end
    return PULL;
  endfunction

  task automatic model_step();
    int o;
    bit wr;
    bit [7:0] d;
    bit tk [NUM_CH];
    bit ns [NUM_CH];
    if (I_RESET) begin
      m_pre = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_cnt[c] = 0; m_mod[c] = 0; m_en[c] = 0; m_os[c] = 0; m_irq[c] = 0;
        m_rate[c] = 0; m_selq[c] = 0; m_flag[c] = 0;
      end
      return;
    end
    wr = !I_WE_L;
    d  = tb_wdata;
    o  = wr ? blk_off(I_ADDR) : -1;
    for (int c = 0; c < NUM_CH; c++) begin
      ns[c] = tap_val(c);
      tk[c] = m_selq[c] && !ns[c];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      bit old_os = m_os[c];
      bit w_cnt  = (o == 4 + 4 * c);
      bit w_mod  = (o == 5 + 4 * c);
      bit w_ctl  = (o == 6 + 4 * c);
      bit over   = tk[c] && m_cnt[c] == 8'hFF && !w_cnt;
      if (w_cnt) m_cnt[c] = d;
      else if (over) m_cnt[c] = w_mod ? d : m_mod[c];
      else if (tk[c]) m_cnt[c] = m_cnt[c] + 8'd1;
      if (w_mod) m_mod[c] = d;
      if (w_ctl) begin
        m_en[c] = d[0]; m_rate[c] = d[2:1]; m_os[c] = d[3]; m_irq[c] = d[4];
      end
      if (over && old_os) m_en[c] = 0;
      if (o == 1 && d[c]) m_flag[c] = 0;
      if (over) m_flag[c] = 1;
      m_selq[c] = ns[c];
    end
    m_pre = (o == 0) ? 16'd0 : m_pre + 16'd1;
  endtask

  always @(posedge I_CLOCK) model_step();

  // ---------------- scoreboard + monitor ----------------
  logic [7:0] exp_q [$];
  string      name_q [$];

  always @(negedge I_CLOCK) begin
    if (checks_on) begin
      logic [NUM_CH-1:0] ef;
      logic ei;
      ef = '0;
      ei = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        ef[c] = m_flag[c];
        ei    = ei | (m_flag[c] & m_irq[c]);
      end
      check("o_flags", 16'(O_FLAGS), 16'(ef));
      check("o_irq", 16'(O_TIMER_INTERRUPT), 16'(ei));
      check("o_div", 16'(O_DIV_DATA), 16'(m_pre[15:8]));
      if (!I_RE_L) begin
        if (exp_q.size() == 0) check("read_without_expectation", 16'(io_data), 16'hFFFF);
        else check(name_q.pop_front(), 16'(io_data), 16'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- bus tasks (entered at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge I_CLOCK); #1; end
  endtask

  task automatic push_read(input logic [15:0] a, input logic [7:0] e, input string nm);
    I_ADDR = a;
    I_RE_L = 1'b0;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge I_CLOCK); #1;
    I_RE_L = 1'b1;
  endtask

  task automatic do_read(input logic [15:0] a);
    push_read(a, model_read(a), $sformatf("read_%h", a));
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    I_ADDR = a; tb_wdata = d; tb_drive = 1'b1; I_WE_L = 1'b0;
    @(posedge I_CLOCK); #1;
    I_WE_L = 1'b1; tb_drive = 1'b0;
  endtask

  task automatic wait_tick(input int c);
    for (int i = 0; i < 4000; i++) begin
      if (tick_next(c)) return;
      @(posedge I_CLOCK); #1;
    end
    check("wait_tick_timeout", 16'd1, 16'd0);
  endtask

  task automatic wait_div_bit4();
    for (int i = 0; i < 100; i++) begin
      if (m_pre[4]) return;
      @(posedge I_CLOCK); #1;
    end
    check("wait_div_timeout", 16'd1, 16'd0);
  endtask

  initial begin
    idle(3);
    I_RESET = 1'b0;
    checks_on = 1'b1;

    // Reset values and undecoded holes.
    for (int o = -1; o < SPAN + 2; o++) do_read(16'(int'(BASE) + o));
    push_read(BASE + 16'd3, PULL, "hole_plus3");
    push_read(BASE + 16'd7, PULL, "hole_plus7");
    push_read(16'h0000, PULL, "outside");

    // Ch0 overflow with reload and IRQ, then W1C.
    do_write(BASE + 16'd6, 8'h13);
    do_write(BASE + 16'd5, 8'hF0);
    do_write(BASE + 16'd4, 8'hFE);
    for (int i = 0; i < 80; i++) do_read(BASE + 16'd4);
    do_read(BASE + 16'd1);
    do_write(BASE + 16'd1, 8'h01);
    do_read(BASE + 16'd1);

    // Ch1 one-shot: fires once, then holds.
    do_write(BASE + 16'd9, 8'h55);
    do_write(BASE + 16'd8, 8'hFF);
    do_write(BASE + 16'd10, 8'h0D);
    for (int i = 0; i < 50; i++) begin do_read(BASE + 16'd8); idle(3); end
    idle(1000);
    push_read(BASE + 16'd8, 8'h55, "oneshot_cnt_hold");
    push_read(BASE + 16'd10, 8'h0C, "oneshot_ctl_cleared");

    // DIV write while ch0's tap is high: prescaler clears, one extra tick.
    do_write(BASE + 16'd4, 8'h20);
    wait_div_bit4();
    do_write(BASE + 16'd0, 8'hA5);
    push_read(BASE, 8'h00, "div_after_write");
    do_read(BASE + 16'd4);

    // CNT write on the overflow edge wins; MOD write on the overflow edge reloads new data.
    do_write(BASE + 16'd1, 8'hFF);
    do_write(BASE + 16'd4, 8'hFF);
    wait_tick(0);
    do_write(BASE + 16'd4, 8'h10);
    push_read(BASE + 16'd4, 8'h10, "cnt_write_wins");
    push_read(BASE + 16'd1, 8'h00, "no_flag_on_cnt_write");
    do_write(BASE + 16'd4, 8'hFF);
    wait_tick(0);
    do_write(BASE + 16'd5, 8'h77);
    push_read(BASE + 16'd4, 8'h77, "mod_write_reload");

    // Flag set and W1C on the same edge: set wins.
    do_write(BASE + 16'd1, 8'hFF);
    do_write(BASE + 16'd4, 8'hFF);
    wait_tick(0);
    do_write(BASE + 16'd1, 8'h01);
    push_read(BASE + 16'd1, 8'h01, "set_beats_w1c");

    // Reset during a bus write.
    I_ADDR = BASE + 16'd4; tb_wdata = 8'hAB; tb_drive = 1'b1; I_WE_L = 1'b0; I_RESET = 1'b1;
    @(posedge I_CLOCK); #1;
    I_WE_L = 1'b1; tb_drive = 1'b0; I_RESET = 1'b0;
    for (int o = 0; o < SPAN; o++)
      if (o % 4 != 3 && o != 2) push_read(16'(int'(BASE) + o), 8'h00, $sformatf("post_reset_%0d", o));

    // Randomised traffic, biased towards near-overflow counts.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [15:0] a;
      logic [7:0]  d;
      r = $urandom_range(0, 3);
      a = 16'(int'(BASE) - 2 + $urandom_range(0, SPAN + 3));
      d = ($urandom_range(0, 1) == 1) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      if (r == 0) do_write(a, d);
      else if (r == 1) do_read(a);
      else idle(1);
    end

    idle(2);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gbc_timer_array.md
Name: gbc_timer_array

Overview:
- Multi-channel memory-mapped timer block for the GBC system bus, driven by the 2^23 Hz system clock.
- One free-running 16-bit prescaler provides a DIV register and rate taps. NUM_CH independent 8-bit counters each have a modulo reload, a per-channel rate select, a one-shot or periodic mode, and a sticky interrupt flag.
- Generalises the single DMG-style TIMA/TMA/TAC timer to N channels, adding W1C flags, IRQ masking and one-shot mode.

Parameters:
- NUM_CH, 2, number of counter channels (1..8).
- BASE_ADDR, 16'hFF80, address of the first register in the block.
- TAP0, 10, prescaler bit used for rate 00 (4096 Hz).
- TAP1, 4, prescaler bit used for rate 01 (262144 Hz).
- TAP2, 6, prescaler bit used for rate 10 (65536 Hz).
- TAP3, 8, prescaler bit used for rate 11 (16384 Hz).

Ports:
- I_CLOCK  in  1  system clock, 2^23 Hz.
- I_RESET  in  1  synchronous, active-high reset.
- I_ADDR  in  16  bus address.
- IO_DATA  inout  8  bus data. Driven only during a matching read, otherwise Z.
- I_RE_L  in  1  bus read strobe, active low.
- I_WE_L  in  1  bus write strobe, active low. Data is sampled on the I_CLOCK edge.
- O_TIMER_INTERRUPT  out  1  OR of (flag & irq_en) over all channels.
- O_FLAGS  out  NUM_CH  raw sticky flags, for debug.
- O_DIV_DATA  out  8  prescaler[15:8], for debug.

Behaviour:
- Clock and reset: one clock, I_CLOCK. Reset is synchronous, active-high, I_RESET.
- Address map (offsets from BASE_ADDR):
  - +0 DIV.
  - +1 IF: bit n = flag of channel n. Bits >= NUM_CH read 0.
  - Channel n at +4+4n: +0 CNT, +1 MOD, +2 CTL. CTL fields: [0] enable, [2:1] rate, [3] one_shot, [4] irq_en, [7:5] read 0.
  - +3 of each channel group, and all unmapped offsets: not decoded, IO_DATA stays Z.
- Reset: prescaler, all CNT/MOD/CTL, all flags and all edge-detect registers clear to 0. O_TIMER_INTERRUPT=0, O_FLAGS=0, O_DIV_DATA=0.
- Prescaler:
  - Increments by 1 every cycle and wraps at 16'hFFFF.
  - Any write to DIV clears the whole prescaler to 0 on that edge; the write data is ignored.
- Tick generation, per channel:
  - sel = tap bit chosen by rate, ANDed with enable.
  - sel_q <= sel every cycle. tick = sel_q & ~sel (falling edge).
  - Consequences, intended for DMG compatibility: clearing enable, changing rate, or writing DIV while the selected tap is 1 produces exactly one extra tick.
- Counter update on the edge where tick=1:
  - CNT != 8'hFF: CNT <= CNT+1.
  - CNT == 8'hFF: CNT <= MOD, flag <= 1. If one_shot=1, enable <= 0 on the same edge.
- Priority for simultaneous events:
  - CPU write to CNT on a tick edge: the write wins. No increment, no flag.
  - CPU write to MOD on an overflow edge: the reload uses the new write data.
  - CPU write to CTL on a tick edge: CNT still updates from the tick. The one-shot enable clear overrides an enable bit written on the same edge.
  - W1C: writing 1 to IF bit n clears flag n; writing 0 leaves it unchanged. A flag set on the same edge as a W1C clear stays 1 (set wins).
- Interrupt:
  - O_TIMER_INTERRUPT is combinational from registered state.
  - It rises the cycle after the overflow edge and stays high until the flag is cleared or irq_en=0.
  - The flag sets on overflow regardless of irq_en.
- Bus:
  - Reads are combinational. IO_DATA is driven while I_RE_L=0 and the address matches; reads have no side effects.
  - Writes take effect on the I_CLOCK edge while I_WE_L=0 and the address matches.
- Reset mid-operation: a reset asserted on any edge overrides every write and tick on that edge.

Test Plan:
- Reset, then read every register -> all read 0. IO_DATA is Z at BASE+3, BASE+7 and outside the block.
- Ch0: CTL=8'h13 (enable, rate 01, irq_en), MOD=8'hF0, CNT=8'hFE -> CNT=8'hFF 32 cycles later. On the next 32-cycle tick CNT=8'hF0, IF[0]=1 and the IRQ rises one cycle later. Write IF=8'h01 -> IRQ falls.
- Ch1: one_shot, rate 10, CNT=8'hFF, MOD=8'h55 -> after the first tick, at 128 cycles: CNT=8'h55, CTL[0]=0. CNT stays 8'h55 for 1000 further cycles.
- Write DIV while ch0 runs rate 01 with prescaler[4]=1 -> prescaler becomes 0, CNT increments once extra, DIV reads 0.
- Write CNT=8'h10 on the exact tick edge with CNT=8'hFF -> CNT=8'h10, no flag. Separately, write MOD=8'h77 on an overflow edge -> CNT=8'h77.
- Flag set and W1C on the same edge -> flag stays 1. Assert I_RESET during a bus write -> all registers read 0.
